serial_add_ctrl: RTL
====================

// Module: serial_add_ctrl
// PURPOSE
//  Sequencer that reuses a single 1-bit FullAdder cell to add or subtract two
//  WIDTH-bit operands, one bit per clock, LSB first. It latches the operands,
//  schedules the carry chain through the shared cell, and assembles the result.
//  It sits in front of the ALU datapath as the area-minimal adder option, using
//  a start/busy/done handshake.
// PARAMETERS
//  WIDTH   16   operand/result width in bits (>=2)
// PORTS
//  clk       in   1      single clock, all state updates on rising edge
//  reset     in   1      synchronous, active-high; sampled on rising clk edge
//  start     in   1      request; sampled only in IDLE or DONE
//  sub       in   1      0: a+b+cin   1: a-b (b inverted, carry-in forced 1, cin ignored)
//  a         in   WIDTH  operand A, latched at accept edge
//  b         in   WIDTH  operand B, latched at accept edge
//  cin       in   1      carry-in for add; latched at accept edge
//  busy      out  1      1 while state==RUN
//  done      out  1      1 for exactly one cycle when the result is valid
//  sum       out  WIDTH  result; holds its value until the next completion
//  cout      out  1      carry out of MSB (for sub: 1 = no borrow)
//  ovf       out  1      signed overflow = carry into MSB ^ carry out of MSB
// BEHAVIOUR
//  - Reset (sync): state=IDLE; busy=0; done=0; sum=0; cout=0; ovf=0;
//    bit counter=0; operand shift registers cleared. Reset wins over start.
//  - FSM states: IDLE -> RUN -> DONE -> IDLE.
//    IDLE: if start, latch a, (sub ? ~b : b), and carry=(sub ? 1 : cin);
//      set cnt=0; go to RUN.
//    RUN: each edge feeds opA[0], opB[0], carry into FullAdder; shifts the
//      sum bit into result[WIDTH-1] (right shift); shifts opA and opB right;
//      carry<=carry_out; cnt++. On the edge where cnt==WIDTH-1: record
//      carry-in of this bit as c_msb_in, go to DONE, and commit sum, cout and
//      ovf to the outputs.
//    DONE: done=1 for one cycle. If start is high, perform the IDLE accept
//      and go to RUN (back-to-back operation). Otherwise go to IDLE.
//  - Latency: the accept edge is E0. busy is high for WIDTH cycles (E0..E_W).
//    The outputs update at E_W. done is high in the cycle E_W..E_W+1.
//  - start while RUN: ignored. No queueing. Operand inputs may change freely
//    after the accept edge.
//  - sum, cout and ovf change only at the completion edge (or reset). They
//    remain stable through DONE/IDLE/RUN of the next operation.
//  - Arithmetic is modulo 2^WIDTH. Subtraction is two's complement a + ~b + 1.
//  - Reset asserted mid-RUN aborts the operation. No done pulse. Outputs return
//    to 0 on that edge.
//  - done and busy are never high in the same cycle.
// TESTING (WIDTH=16)
//  1. a=FFFF b=0001 cin=0 sub=0, pulse start -> 16 busy cycles, then done=1;
//     sum=0000 cout=1 ovf=0.
//  2. a=7FFF b=0001 cin=0 sub=0 -> sum=8000 cout=0 ovf=1; a=1234 b=4321 cin=1
//     -> sum=5556 cout=0 ovf=0.
//  3. sub=1 a=0005 b=0007 cin=1 -> sum=FFFE cout=0 ovf=0 (cin ignored);
//     a=8000 b=0001 -> sum=7FFF cout=1 ovf=1.
//  4. Hold start high during RUN with different operands -> the first result is
//     unchanged. Exactly one done per accepted start. With start held, a
//     back-to-back op is accepted in the DONE cycle; busy re-asserts next cycle.
//  5. Assert reset at RUN cycle 7 -> next cycle busy=0 done=0 sum=0; no done
//     afterwards. A new start completes normally with the correct result.
//  6. Randomized 1000 ops (add/sub) vs. a behavioural a+b+cin model. Check
//     latency == WIDTH cycles every time and sum stable between done pulses.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one shared 1-bit full adder is stepped
// LSB-first across WIDTH clocks behind a start/busy/done handshake.

module serial_add_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_acc_next;

  serial_add_fa u_fa (
    .i_a (r_opa[0]),
    .i_b (r_opb[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  // Sum bits enter at the MSB so the word is LSB-aligned after WIDTH shifts.
  assign w_acc_next = {w_s, r_acc[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_opa   <= a;
            r_opb   <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_opa   <= r_opa >> 1;
          r_opb   <= r_opb >> 1;
          r_acc   <= w_acc_next;
          r_carry <= w_c;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            // r_carry is still the carry into the MSB on this edge.
            sum     <= w_acc_next;
            cout    <= w_c;
            ovf     <= r_carry ^ w_c;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
